// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: word-to-serial loader for a scan configuration chain.
// Optional readback verify is enabled by defining CFG_CHAIN_READBACK_EN.
module cfg_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic              CK,
   input  logic              RSTN,
   input  logic              start,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              SO,
   output logic              SI,
   output logic              sc_en,
   output logic              SE,
   output logic              CFGE,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int BW = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] LEN_C = CW'(CHAIN_LEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
`ifdef CFG_CHAIN_READBACK_EN
      S_VERIFY,
`endif
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [BW-1:0]     bleft_q, bleft_d;
   logic [CW-1:0]     lrem_q, lrem_d;
   logic              si_q, si_d;
   logic              sc_en_q, sc_en_d;
   logic              se_q, se_d;
   logic              cfge_q, cfge_d;
   logic              done_q, done_d;
   logic [CW-1:0]     nb;
   logic              take;

`ifdef CFG_CHAIN_READBACK_EN
   logic              err_q, err_d;
   logic [CW-1:0]     ones_ld_q, ones_ld_d;
   logic [CW-1:0]     ones_rb_q, ones_rb_d;
`endif

   // Ready only when the buffer is about to run dry and bits remain to load.
   assign in_ready = (state_q == S_LOAD) && (bleft_q <= BW'(1)) &&
                     (lrem_q != '0);
   assign take     = in_valid && in_ready;
   // The last word may carry fewer useful bits than WORD_W.
   assign nb       = (int'(lrem_q) >= WORD_W) ? CW'(WORD_W) : lrem_q;

   // Next-state and next-output computation for the load sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bleft_d = bleft_q;
      lrem_d  = lrem_q;
      si_d    = si_q;
      sc_en_d = 1'b0;
      se_d    = se_q;
      cfge_d  = cfge_q;
      done_d  = done_q;
`ifdef CFG_CHAIN_READBACK_EN
      err_d     = err_q;
      ones_ld_d = ones_ld_q;
      ones_rb_d = ones_rb_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               sh_d    = '0;
               bleft_d = '0;
               lrem_d  = LEN_C;
               se_d    = 1'b1;
               cfge_d  = 1'b0;
               done_d  = 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
               err_d     = 1'b0;
               ones_ld_d = '0;
               ones_rb_d = '0;
`endif
            end
         end
         S_LOAD: begin
            if (cnt_q == LEN_C) begin
`ifdef CFG_CHAIN_READBACK_EN
               state_d = S_VERIFY;
               cnt_d   = '0;
               sc_en_d = 1'b1;
`else
               state_d = S_DONE;
               se_d    = 1'b0;
               cfge_d  = 1'b1;
               done_d  = 1'b1;
`endif
            end else begin
               if (bleft_q != '0) begin
                  si_d    = sh_q[0];
                  sc_en_d = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
                  sh_d    = sh_q >> 1;
                  bleft_d = bleft_q - 1'b1;
`ifdef CFG_CHAIN_READBACK_EN
                  ones_ld_d = ones_ld_q + CW'(sh_q[0]);
`endif
               end
               if (take) begin
                  sh_d    = in_data;
                  bleft_d = BW'(nb);
                  lrem_d  = lrem_q - nb;
               end
            end
         end
`ifdef CFG_CHAIN_READBACK_EN
         S_VERIFY: begin
            ones_rb_d = ones_rb_q + CW'(SO);
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LEN_C - 1'b1) begin
               state_d = S_DONE;
               se_d    = 1'b0;
               cfge_d  = 1'b1;
               done_d  = 1'b1;
               err_d   = (ones_ld_q != ones_rb_d);
            end else begin
               sc_en_d = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         bleft_q <= '0;
         lrem_q  <= '0;
         si_q    <= 1'b0;
         sc_en_q <= 1'b0;
         se_q    <= 1'b0;
         cfge_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
         err_q     <= 1'b0;
         ones_ld_q <= '0;
         ones_rb_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bleft_q <= bleft_d;
         lrem_q  <= lrem_d;
         si_q    <= si_d;
         sc_en_q <= sc_en_d;
         se_q    <= se_d;
         cfge_q  <= cfge_d;
         done_q  <= done_d;
`ifdef CFG_CHAIN_READBACK_EN
         err_q     <= err_d;
         ones_ld_q <= ones_ld_d;
         ones_rb_q <= ones_rb_d;
`endif
      end
   end

   assign sc_en = sc_en_q;
   assign SE    = se_q;
   assign CFGE  = cfge_q;
   assign done  = done_q;

`ifdef CFG_CHAIN_READBACK_EN
   // During verify the chain tail is looped straight back to its head.
   assign SI  = (state_q == S_VERIFY) ? SO : si_q;
   assign err = err_q;
`else
   logic unused_so;
   assign unused_so = SO;
   assign SI  = si_q;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: randomized bench with a bit-stream reference model.
// Readback expectations follow CFG_CHAIN_READBACK_EN.
module tb_cfg_chain_loader;

   localparam int N  = 20;
   localparam int W  = 8;
   localparam int NW = (N + W - 1) / W;
`ifdef CFG_CHAIN_READBACK_EN
   localparam int RB = N;
`else
   localparam int RB = 0;
`endif

   logic         CK = 1'b0;
   logic         RSTN;
   logic         start, in_valid, in_ready, SO, SI;
   logic         sc_en, SE, CFGE, done, err;
   logic [W-1:0] in_data;

   logic         b_start, b_valid, b_ready, b_so, b_si;
   logic         b_sc_en, b_se, b_cfge, b_done, b_err;
   logic [7:0]   b_data;

   logic [N-1:0] chain = '0;
   bit           so_zero;
   logic [W-1:0] words [NW];
   int           gaps [NW];
   int           errs;
   int           checks;

   always #5 CK = ~CK;

   cfg_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) u_dut (
      .CK(CK), .RSTN(RSTN), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .SO(SO), .SI(SI),
      .sc_en(sc_en), .SE(SE), .CFGE(CFGE), .done(done), .err(err)
   );

   cfg_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
      .CK(CK), .RSTN(RSTN), .start(b_start), .in_data(b_data),
      .in_valid(b_valid), .in_ready(b_ready), .SO(b_so), .SI(b_si),
      .sc_en(b_sc_en), .SE(b_se), .CFGE(b_cfge), .done(b_done), .err(b_err)
   );

   // Ideal downstream scan chain: head at bit 0, tail at bit N-1.
   assign SO = so_zero ? 1'b0 : chain[N-1];
   always @(posedge CK) if (sc_en) chain <= {chain[N-2:0], SI};

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_load(input bit mid_start, input int rst_at);
      logic [N-1:0] exp_s, got_s, exp_c;
      int  wi, gap, nshift, nbub, bub_err, cyc, acc_edge, sumgap, ones;
      bit  acc, prev_si, seen_done, last_sc, exp_err;
      ones   = 0;
      sumgap = 0;
      for (int k = 0; k < N; k++) begin
         exp_s[k]       = words[k / W][k % W];
         exp_c[N-1-k]   = exp_s[k];
         ones          += int'(exp_s[k]);
      end
      for (int i = 1; i < NW; i++) sumgap += gaps[i];
      exp_err = (RB > 0) && so_zero && (ones != 0);

      in_valid = 1'b0;
      start    = 1'b1;
      @(posedge CK); #1;
      start = 1'b0;
      check("start_se", SE, 1);
      check("start_cfge", CFGE, 0);
      check("start_done", done, 0);

      wi = 0; gap = 0; nshift = 0; nbub = 0; bub_err = 0;
      cyc = 0; acc_edge = -1; seen_done = 0; got_s = '0;
      prev_si = SI; last_sc = 1'b0;
      while (!seen_done && cyc < 400) begin
         in_data = W'($urandom);
         if (wi < NW && gap == 0) begin
            in_valid = 1'b1;
            in_data  = words[wi];
         end else if (wi < NW && in_ready) begin
            in_valid = 1'b0;
            gap--;
         end else begin
            in_valid = 1'($urandom_range(0, 1));
         end
         acc   = in_valid && in_ready;
         start = mid_start && (cyc == 6);
         @(posedge CK); #1;
         start = 1'b0;
         cyc++;
         if (acc) begin
            if (acc_edge < 0) acc_edge = cyc;
            wi++;
            if (wi < NW) gap = gaps[wi];
         end
         if (sc_en) begin
            if (nshift < N) got_s[nshift] = SI;
            nshift++;
         end else if (SE && nshift > 0) begin
            nbub++;
            if (SI !== prev_si) bub_err++;
         end
         if (done) begin
            seen_done = 1'b1;
            check("sc_en_before_done", last_sc, 1);
         end
         last_sc = sc_en;
         prev_si = SI;
         if (rst_at > 0 && nshift == rst_at) begin
            #3 RSTN = 1'b0;
            #1;
            check("arst_se", SE, 0);
            check("arst_sc_en", sc_en, 0);
            check("arst_cfge", CFGE, 0);
            check("arst_ready", in_ready, 0);
            in_valid = 1'b0;
            @(negedge CK);
            RSTN = 1'b1;
            return;
         end
      end
      in_valid = 1'b0;
      check("done_seen", seen_done, 1);
      check("shift_count", nshift, N + RB);
      check("si_stream", got_s, exp_s);
      check("words_taken", wi, NW);
      check("bubbles", nbub, sumgap);
      check("bubble_hold", bub_err, 0);
      check("latency", cyc - acc_edge, N + 1 + RB + sumgap);
      check("cfge", CFGE, 1);
      check("se_off", SE, 0);
      check("err", err, exp_err);
      if (!so_zero) check("chain", chain, exp_c);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge CK); #1;
         check("hold_ready", in_ready, 0);
         check("hold_done", done, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic small_load();
      int       acc8, rdy8, ns, ones8;
      logic [7:0] s8;
      acc8 = 0; rdy8 = 0; ns = 0; ones8 = 0; s8 = '0;
      b_start = 1'b1;
      @(posedge CK); #1;
      b_start = 1'b0;
      b_valid = 1'b1;
      b_data  = 8'h01;
      for (int c = 0; c < 60 && !b_done; c++) begin
         if (b_ready) rdy8++;
         if (b_valid && b_ready) acc8++;
         @(posedge CK); #1;
         if (b_sc_en) begin
            if (ns < 8) s8[ns] = b_si;
            ones8 += int'(b_si);
            ns++;
         end
      end
      b_valid = 1'b0;
      check("s8_done", b_done, 1);
      check("s8_words", acc8, 1);
      check("s8_ready_cycles", rdy8, 1);
      check("s8_stream", s8, 8'h01);
      check("s8_ones", ones8, 1);
      check("s8_shifts", ns, 8 + RB);
      check("s8_cfge", b_cfge, 1);
      check("s8_err", b_err, RB > 0);
   endtask

   initial begin
      errs = 0; checks = 0; so_zero = 1'b0;
      RSTN = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      b_start = 1'b0; b_valid = 1'b0; b_data = '0; b_so = 1'b0;
      #12;
      check("rst_si", SI, 0);
      check("rst_sc_en", sc_en, 0);
      check("rst_se", SE, 0);
      check("rst_cfge", CFGE, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready", in_ready, 0);
      check("rst_b_ready", b_ready, 0);
      @(negedge CK);
      RSTN = 1'b1;
      @(posedge CK); #1;
      check("idle_ready", in_ready, 0);

      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      gaps[0] = 0; gaps[1] = 0; gaps[2] = 0;
      do_load(1'b0, 0);
      gaps[1] = 3; gaps[2] = 3;
      do_load(1'b0, 0);
      gaps[1] = 0; gaps[2] = 1;
      do_load(1'b1, 0);

      words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h0F;
      do_load(1'b0, 10);
      do_load(1'b0, 0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NW; i++) begin
            words[i] = W'($urandom);
            gaps[i]  = (i == 0) ? 0 : $urandom_range(0, 4);
         end
         do_load(1'($urandom_range(0, 1)), 0);
      end

      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      gaps[1] = 0; gaps[2] = 0;
      so_zero = 1'b1;
      do_load(1'b0, 0);
      so_zero = 1'b0;

      small_load();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration-chain loader sitting directly upstream of a chain of scan flip-flops with configure-enable outputs. It accepts parallel configuration words over a valid/ready handshake, serializes them LSB-first onto the chain's scan input, and qualifies each shift. After exactly CHAIN_LEN bits it drops scan enable and asserts configure enable, which releases the chain's registered outputs to the fabric.

## Interface
- CHAIN_LEN, 64: number of flip-flops in the downstream chain; must be ≥ 2.
- WORD_W, 8: input word width; must be ≥ 1.
- CK  input  1  clock; rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle load request.
- in_data  input  WORD_W  configuration word; bit 0 is shifted first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- SO  input  1  chain tail output; used only with the readback feature.
- SI  output  1  scan data to the chain head.
- sc_en  output  1  chain shift qualifier; the chain shifts on an edge only while sc_en=1.
- SE  output  1  scan enable to the chain.
- CFGE  output  1  configure enable to the chain.
- done  output  1  load complete.
- err  output  1  readback mismatch; sticky until the next start.

## Operation
- States: IDLE, LOAD, VERIFY (present only with the readback feature), DONE.
- Reset values: state=IDLE; SI, sc_en, SE, CFGE, done, err, in_ready all 0; bit counter 0; shift buffer empty.
- IDLE: start=1 moves to LOAD. All outputs are 0.
- LOAD:
  - SE=1 throughout; bit counter cleared on entry.
  - in_ready = (buffer empty, or exactly 1 bit left) AND (bits not yet loaded into the buffer > 0).
  - A word is accepted when in_valid && in_ready.
  - Each cycle the buffer holds a bit: SI gets buffer[0], sc_en=1, buffer shifts right, counter increments.
  - Cycles with no buffered bit: sc_en=0 (bubble) and SI holds its value.
  - Total words consumed = ceil(CHAIN_LEN/WORD_W). Upper bits of the final word beyond CHAIN_LEN are discarded and never shifted.
  - When the counter reaches CHAIN_LEN, move to VERIFY if configured, otherwise to DONE.
- DONE: SE=0, sc_en=0, CFGE=1, done=1. Holds until start.
- start in DONE: re-enters LOAD; CFGE and done clear in the cycle after start.
- start in LOAD or VERIFY is ignored.
- in_valid outside LOAD is ignored; in_ready=0 there.
- RSTN asserted at any time, mid-load included, returns to the reset values immediately. A partially loaded chain is not configured (CFGE=0).

## Timing
- SI, sc_en, SE, CFGE, done, err are registered. in_ready is combinational from state and registers only, never from in_valid.
- Word accepted at edge t: its bit 0 appears on SI with sc_en=1 in cycle t+1.
- Back-to-back words shift without bubbles: WORD_W sc_en cycles per word.
- Minimum load time: CHAIN_LEN cycles after the first word is accepted.
- Final sc_en=1 cycle is followed immediately by SE=0, CFGE=1, done=1 (no readback) or by VERIFY.
- start to SE=1: 1 cycle.

## Configuration
- Macro CFG_CHAIN_READBACK_EN.
- Defined:
  - During LOAD, a ones-count of shifted bits is accumulated (width clog2(CHAIN_LEN+1)).
  - VERIFY runs for exactly CHAIN_LEN cycles with SE=1 and sc_en=1. SI is driven combinationally from SO, which rotates the chain back to its loaded contents.
  - A second ones-count is taken over SO.
  - On exit to DONE, err=1 if the two counts differ.
  - Total latency increases by CHAIN_LEN cycles.
- Undefined: VERIFY does not exist, SO is ignored, and err is tied to 0.

## Test plan
- CHAIN_LEN=20, WORD_W=8. start, then words 0xA5, 0x3C, 0xFF with in_valid held high. Required:
  - exactly 20 sc_en pulses;
  - SI sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1;
  - CFGE=done=1 in the cycle after the 20th shift;
  - in_ready=0 afterwards.
- Same load with in_valid low for 3 cycles between words: 3 bubble cycles with sc_en=0 and SI unchanged; final chain contents identical to the previous case.
- RSTN pulsed low after 10 shifts: SE, sc_en, CFGE drop asynchronously. A following start and full load completes normally with the counter restarting from 0.
- start in DONE: CFGE=0 and SE=1 on the next cycle. start pulsed mid-LOAD: no effect on the counter or SI.
- With CFG_CHAIN_READBACK_EN, load 0xA5,0x3C,0xFF:
  - ideal chain model loops SO to the chain: done after 40 shift cycles, err=0;
  - SO forced to 0: err=1 and CFGE=1.
- CHAIN_LEN=8, WORD_W=8, single word 0x01: one word consumed, in_ready never rises again, SI=1 only in the first shift cycle.
